// File: rtl/ifetch.sv
// Instruction fetch unit.
// Owns the program counter, fetches instruction words over a
// request/ready handshake and presents each word with a one-cycle
// load strobe for the instruction register. PC redirects (relative
// branch, absolute jump) are taken only while idle.
//
// Handshake: imem_req_out is raised the cycle after a fetch is
// accepted and stays high, with imem_addr_out stable, until the first
// rising edge at which imem_ready_in is sampled high (that edge
// completes the transfer and captures imem_rdata_in) or until the
// wait budget runs out (the request is then withdrawn without a
// transfer). Ready is honoured on the very first request cycle.
module ifetch #(
  parameter logic [15:0] RESET_PC = 16'h0000,
  parameter int unsigned MAX_WAIT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        fetch_in,
  input  logic        branch_in,
  input  logic [15:0] ia_in,
  input  logic        jump_in,
  input  logic [15:0] jaddr_in,
  input  logic [15:0] imem_rdata_in,
  input  logic        imem_ready_in,
  output logic        imem_req_out,
  output logic [15:0] imem_addr_out,
  output logic [15:0] ins_out,
  output logic        il_out,
  output logic [15:0] pc_out,
  output logic        busy_out,
  output logic        err_out,
  output logic [1:0]  state_dbg
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    LOAD = 2'd2
  } state_t;

  // Wait count at which one more unanswered request cycle aborts.
  localparam logic [15:0] WAIT_LAST = 16'(MAX_WAIT - 1);

  state_t      state;
  state_t      state_nx;
  logic [15:0] pc;
  logic [15:0] pc_nx;
  logic [15:0] pc_tgt;
  logic [15:0] ins;
  logic [15:0] ins_nx;
  logic [15:0] wait_cnt;
  logic [15:0] wait_nx;
  logic        req;
  logic        req_nx;
  logic        il;
  logic        il_nx;
  logic        busy;
  logic        busy_nx;
  logic        err;
  logic        err_nx;

  // Redirect target seen from IDLE: jump beats branch, branch wraps mod 2^16.
  always_comb begin
    pc_tgt = pc;
    if (jump_in) begin
      pc_tgt = jaddr_in;
    end else if (branch_in) begin
      pc_tgt = pc + ia_in;
    end
  end

  // Next-state and next-output logic for the fetch sequencer.
  always_comb begin
    state_nx = state;
    pc_nx    = pc;
    ins_nx   = ins;
    wait_nx  = wait_cnt;
    req_nx   = req;
    err_nx   = err;
    unique case (state)
      IDLE: begin
        // A redirect and a fetch together fetch from the new target,
        // because the address register is loaded with pc_tgt.
        pc_nx   = pc_tgt;
        wait_nx = '0;
        if (fetch_in) begin
          state_nx = REQ;
          req_nx   = 1'b1;
        end else begin
          req_nx   = 1'b0;
        end
      end
      REQ: begin
        if (imem_ready_in) begin
          ins_nx   = imem_rdata_in;
          pc_nx    = pc + 16'd1;
          req_nx   = 1'b0;
          wait_nx  = '0;
          state_nx = LOAD;
        end else if (wait_cnt == WAIT_LAST) begin
          // Budget exhausted: give up, keep PC and instruction word.
          err_nx   = 1'b1;
          req_nx   = 1'b0;
          wait_nx  = '0;
          state_nx = IDLE;
        end else begin
          wait_nx  = wait_cnt + 16'd1;
        end
      end
      LOAD: begin
        req_nx   = 1'b0;
        state_nx = IDLE;
      end
      default: begin
        req_nx   = 1'b0;
        wait_nx  = '0;
        state_nx = IDLE;
      end
    endcase
    // Strobe and busy are registered images of the state being entered.
    il_nx   = (state_nx == LOAD);
    busy_nx = (state_nx != IDLE);
  end

  // State, datapath and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      pc       <= RESET_PC;
      ins      <= '0;
      wait_cnt <= '0;
      req      <= 1'b0;
      il       <= 1'b0;
      busy     <= 1'b0;
      err      <= 1'b0;
    end else begin
      state    <= state_nx;
      pc       <= pc_nx;
      ins      <= ins_nx;
      wait_cnt <= wait_nx;
      req      <= req_nx;
      il       <= il_nx;
      busy     <= busy_nx;
      err      <= err_nx;
    end
  end

  // The memory address is the PC itself, so the two can never disagree.
  assign imem_req_out  = req;
  assign imem_addr_out = pc;
  assign pc_out        = pc;
  assign ins_out       = ins;
  assign il_out        = il;
  assign busy_out      = busy;
  assign err_out       = err;
  assign state_dbg     = state;

endmodule
